// File: rtl/rst_seq_multi_if.sv
// +----------------------------------------------------------------------+
// | rst_seq_multi_if : control/status bundle of the reset sequencer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface rst_seq_multi_if #(
    parameter int N_CH = 3
);
    logic            soft_req;
    logic [N_CH-1:0] ch_hold;
    logic [N_CH-1:0] ch_resetn;
    logic            all_ready;
    logic [1:0]      seq_state;
    logic [3:0]      rel_idx;

    modport master (
        output soft_req,
        output ch_hold,
        input  ch_resetn,
        input  all_ready,
        input  seq_state,
        input  rel_idx
    );

    modport slave (
        input  soft_req,
        input  ch_hold,
        output ch_resetn,
        output all_ready,
        output seq_state,
        output rel_idx
    );
endinterface

`default_nettype wire

// File: rtl/rst_seq_multi.sv
// +----------------------------------------------------------------------+
// | rst_seq_multi : multi-channel reset sequencer with stretch and gap   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module rst_seq_multi #(
    parameter int N_CH        = 3,
    parameter int STRETCH     = 15,
    parameter int GAP         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk_p,
    input  wire logic         ext_reset,
    rst_seq_multi_if.slave    bus
);

    localparam int SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [SW-1:0] c_stretch_last = SW'(STRETCH - 1);
    localparam logic [GW-1:0] c_gap_reload   = GW'(GAP - 1);
    localparam logic [3:0]    c_last_idx     = 4'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_s;

    state_e          state_q,   state_d;
    logic [SW-1:0]   stretch_q, stretch_d;
    logic [GW-1:0]   gap_q,     gap_d;
    logic [3:0]      idx_q,     idx_d;
    logic [N_CH-1:0] chr_q,     chr_d;
    logic            rdy_q,     rdy_d;

    logic            w_hold;
    logic [N_CH-1:0] w_sel;

    // Deassertion synchronizer: async clear, ones shift in on each edge.
    always_ff @(posedge clk_p or negedge ext_reset) begin
        if (!ext_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        w_hold = 1'b0;
        w_sel  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx_q == 4'(i)) begin
                w_hold   = bus.ch_hold[i];
                w_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_p or negedge ext_reset) begin
        if (!ext_reset) begin
            state_q   <= ST_ASSERT;
            stretch_q <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            chr_q     <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            chr_q     <= chr_d;
            rdy_q     <= rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        chr_d     = chr_q;
        rdy_d     = rdy_q;

        if (!rst_s) begin
            state_d   = ST_ASSERT;
            stretch_d = '0;
            gap_d     = '0;
            idx_d     = '0;
            chr_d     = '0;
            rdy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    chr_d = '0;
                    rdy_d = 1'b0;
                    idx_d = '0;
                    gap_d = '0;
                    if (bus.soft_req) begin
                        stretch_d = '0;
                    end else if (stretch_q == c_stretch_last) begin
                        state_d   = ST_RELEASE;
                        stretch_d = '0;
                    end else begin
                        stretch_d = stretch_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (bus.soft_req) begin
                        state_d   = ST_ASSERT;
                        stretch_d = '0;
                        gap_d     = '0;
                        idx_d     = '0;
                        chr_d     = '0;
                        rdy_d     = 1'b0;
                    end else if (gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end else if (!w_hold) begin
                        // Release is due (gap drained) and not inhibited.
                        chr_d = chr_q | w_sel;
                        idx_d = idx_q + 4'd1;
                        gap_d = c_gap_reload;
                        if (idx_q == c_last_idx) begin
                            state_d = ST_RUN;
                            rdy_d   = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.soft_req) begin
                        state_d   = ST_ASSERT;
                        stretch_d = '0;
                        gap_d     = '0;
                        idx_d     = '0;
                        chr_d     = '0;
                        rdy_d     = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_ASSERT;
                    stretch_d = '0;
                    gap_d     = '0;
                    idx_d     = '0;
                    chr_d     = '0;
                    rdy_d     = 1'b0;
                end
            endcase
        end
    end

    assign bus.ch_resetn = chr_q;
    assign bus.all_ready = rdy_q;
    assign bus.seq_state = state_q;
    assign bus.rel_idx   = idx_q;

endmodule

`default_nettype wire

// File: doc/rst_seq_multi.md
RST_SEQ_MULTI -- requirements
Module: rst_seq_multi

Interface
REQ-001 Parameter N_CH, default 3, number of sequenced reset channels (legal 1..8).
REQ-002 Parameter STRETCH, default 15, ASSERT-state hold length in clk_p cycles (legal >=1).
REQ-003 Parameter GAP, default 4, cycles between successive channel releases (legal >=1).
REQ-004 Parameter SYNC_STAGES, default 2, depth of the reset-deassertion synchronizer (legal >=2).
REQ-005 clk_p  input  1  clock for all sequential logic.
REQ-006 ext_reset  input  1  asynchronous, active-low reset; already combines board reset and PLL lock.
REQ-007 soft_req  input  1  synchronous single-cycle soft-reset request.
REQ-008 ch_hold  input  N_CH  per-channel release inhibit, synchronous to clk_p.
REQ-009 ch_resetn  output  N_CH  per-channel active-low reset; bit 0 is released first.
REQ-010 all_ready  output  1  high when every channel is released.
REQ-011 seq_state  output  2  current state: 0=ASSERT, 1=RELEASE, 2=RUN.
REQ-012 rel_idx  output  4  index of the next channel due for release; equals N_CH in RUN.

Function
REQ-013 The synchronizer SHALL clear asynchronously on ext_reset low and shift in 1 on each clk_p edge; its last stage is the internal reset rst_s.
REQ-014 While rst_s is low, the block SHALL be in ASSERT with the stretch counter, the gap counter and rel_idx at 0.
REQ-015 In ASSERT, the stretch counter SHALL increment each cycle; when it equals STRETCH-1, the next edge SHALL enter RELEASE with rel_idx=0 and the channel-0 release due.
REQ-016 In RELEASE, the block SHALL set ch_resetn[rel_idx] to 1, increment rel_idx and reload the gap counter on the first edge where the release is due and ch_hold[rel_idx]=0.
REQ-017 The next release SHALL become due after the gap counter has counted GAP cycles.
REQ-018 While ch_hold[rel_idx]=1 and the release is due, the block SHALL defer the release and freeze the gap counter; holding a channel SHALL stall all later channels.
REQ-019 ch_hold bits of already-released channels, and all ch_hold bits in ASSERT or RUN, SHALL be ignored.
REQ-020 On the edge that releases channel N_CH-1, the block SHALL set state to RUN and all_ready to 1; with N_CH=1, this is the edge that releases channel 0.
REQ-021 With no holds, ch_resetn[0] SHALL rise on the (SYNC_STAGES+STRETCH+1)-th rising clk_p edge after ext_reset deasserts, and ch_resetn[i] SHALL rise exactly GAP edges after ch_resetn[i-1].
REQ-022 soft_req=1 in RELEASE or RUN SHALL, on the next edge, drive all ch_resetn to 0 and all_ready to 0, and set state ASSERT with the stretch counter, gap counter and rel_idx at 0.
REQ-023 soft_req=1 in ASSERT SHALL restart the stretch counter at 0.
REQ-024 When soft_req coincides with a due release, soft_req SHALL take precedence and no channel SHALL be released.
REQ-025 ch_resetn SHALL be monotonic within a sequence: once released, a channel stays high until ext_reset or soft_req.
REQ-026 Unused state encoding 3 SHALL transition to ASSERT on the next edge with all channels asserted.
REQ-027 All outputs SHALL be registered and free of combinational paths from inputs.

Reset
REQ-028 ext_reset low SHALL immediately and asynchronously force ch_resetn=0, all_ready=0, seq_state=0, rel_idx=0 and clear all counters, in any state including mid-sequence.
REQ-029 Deassertion of ext_reset SHALL take effect only through the SYNC_STAGES synchronizer; no output SHALL change combinationally on its rising edge.

Verification
REQ-030 Defaults with ext_reset rising before edge 1 and no holds: ch_resetn[0]/[1]/[2] rise at edges 18/22/26; all_ready=1 and seq_state=2 at edge 26.
REQ-031 Defaults with ch_hold[1]=1 from reset until edge 30: ch1 rises at edge 31 and ch2 at edge 35; all_ready rises at edge 35; ch0 is unaffected.
REQ-032 soft_req pulse at edge 40 while in RUN: all ch_resetn=0 after edge 40, and ch0 rises again STRETCH+1=16 edges later (edge 56).
REQ-033 ext_reset pulsed low for 3 ns between edges 20 and 21: outputs drop to 0 asynchronously, and the full sequence restarts with ch0 rising at the 18th edge after the release.
REQ-034 soft_req asserted on edge 22 (ch1 due): ch1 stays 0, ch0 falls, and seq_state=0 after edge 22.
REQ-035 N_CH=1, STRETCH=1, GAP=1: ch_resetn[0] and all_ready rise together at edge 4.
